// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front end.
package mips_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid register that parks a fetch response while decode is stalled.
module if_hold_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            full,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);
    import mips_pkg::*;

    logic            full_q, full_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    // Clear (redirect) beats load, which beats drain.
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= XLEN'(NOP_INSTR);
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full  = full_q;
    assign pc    = pc_q;
    assign instr = instr_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem request FSM and the IF/ID register.
// Handshake: imem_req is a one-cycle request with imem_addr; exactly one imem_valid returns per request.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_id,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [XLEN-1:0] if_id_instr,
    output logic [1:0]      dbg_state
);
    import mips_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;

    logic            hb_full, hb_load, hb_drain;
    logic [XLEN-1:0] hb_pc, hb_instr;
    logic            id_hold, can_issue, issue, rsp;

    assign id_hold   = id_valid_q && stall_id;
    assign can_issue = !hb_full && !id_hold;
    assign rsp       = (state_q == WAIT) && imem_valid;

    always_comb begin
        issue = 1'b0;
        if (!branch_taken) begin
            case (state_q)
                IDLE:    issue = can_issue;
                WAIT:    issue = imem_valid && can_issue;
                default: issue = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (branch_taken) begin
            pc_d = {branch_target[XLEN-1:2], 2'b00};
            if (state_q == WAIT)
                state_d = imem_valid ? IDLE : DISCARD;
            else if (state_q == DISCARD && imem_valid)
                state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (issue) state_d = WAIT;
                WAIT:    if (imem_valid) state_d = issue ? WAIT : IDLE;
                DISCARD: if (imem_valid) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (issue) begin
                pc_d       = pc_q + XLEN'(4);
                req_addr_d = pc_q;
            end
        end
    end

    // A parked response always has priority over a fresh one; both cannot coexist.
    assign hb_load  = !branch_taken && rsp && id_hold;
    assign hb_drain = !branch_taken && hb_full && !id_hold;

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        if (branch_taken) begin
            id_valid_d = 1'b0;
            id_instr_d = XLEN'(NOP_INSTR);
        end else if (id_hold) begin
            id_valid_d = id_valid_q;
        end else if (hb_full) begin
            id_valid_d = 1'b1;
            id_pc_d    = hb_pc;
            id_pc4_d   = hb_pc + XLEN'(4);
            id_instr_d = hb_instr;
        end else if (rsp) begin
            id_valid_d = 1'b1;
            id_pc_d    = req_addr_q;
            id_pc4_d   = req_addr_q + XLEN'(4);
            id_instr_d = imem_rdata;
        end else begin
            id_valid_d = 1'b0;
            id_instr_d = XLEN'(NOP_INSTR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= XLEN'(RESET_PC);
            req_addr_q <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_instr_q <= XLEN'(NOP_INSTR);
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) assert (!(state_q == IDLE && imem_valid));
    end

    if_hold_buf #(.XLEN(XLEN)) u_hold_buf (
        .clk        (clk),
        .rst_n      (reset),
        .load       (hb_load),
        .drain      (hb_drain),
        .clear      (branch_taken),
        .load_pc    (req_addr_q),
        .load_instr (imem_rdata),
        .full       (hb_full),
        .pc         (hb_pc),
        .instr      (hb_instr)
    );

    // Gated by reset so no request escapes while the core is held in reset.
    assign imem_req       = issue && reset;
    assign imem_addr      = pc_q;
    assign if_id_valid    = id_valid_q;
    assign if_id_pc       = id_pc_q;
    assign if_id_pc_plus4 = id_pc4_q;
    assign if_id_instr    = id_instr_q;
    assign dbg_state      = state_q;
endmodule
